// File: rtl/disp_arbiter.sv
// Round-robin arbiter that shares one 4-digit seven-segment display driver between
// N_REQ requesters: grant, latch frame, strobe, track busy, acknowledge, idle gap.
module disp_arbiter #(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned MIN_GAP        = 16,
    parameter int unsigned ACCEPT_TIMEOUT = 8
) (
    input  logic               clk_i,
    input  logic               sync_reset_i,
    input  logic [N_REQ-1:0]   req_i,
    input  logic [N_REQ*32-1:0] req_digits_i,
    input  logic               busy_i,
    output logic [N_REQ-1:0]   grant_o,
    output logic [N_REQ-1:0]   ack_o,
    output logic               err_o,
    output logic [31:0]        digits_o,
    output logic               disp_strobe_o
);

    localparam int unsigned IW      = $clog2(N_REQ);
    localparam int unsigned CNT_MAX = (ACCEPT_TIMEOUT > MIN_GAP) ? ACCEPT_TIMEOUT : MIN_GAP;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STROBE,
        S_ACCEPT,
        S_RUN,
        S_GAP
    } state_t;

    state_t          state;
    logic [IW-1:0]   last_grant;
    logic [CW-1:0]   cnt;

    logic            win_valid_c;
    logic [IW-1:0]   win_idx_c;
    logic [N_REQ-1:0] win_onehot_c;
    logic [31:0]     win_frame_c;

    // last_grant + i never exceeds 2*N_REQ-1, so one conditional subtract wraps it
    function automatic logic [IW-1:0] wrap_idx(input int unsigned v);
        return (v >= N_REQ) ? IW'(v - N_REQ) : IW'(v);
    endfunction

    // Search upward from last_grant+1; iterating far-to-near leaves the nearest winner
    always_comb begin
        win_valid_c  = 1'b0;
        win_idx_c    = '0;
        win_frame_c  = '0;
        for (int unsigned i = N_REQ; i >= 1; i--) begin
            if (req_i[wrap_idx(32'(last_grant) + i)]) begin
                win_valid_c = 1'b1;
                win_idx_c   = wrap_idx(32'(last_grant) + i);
            end
        end
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (win_idx_c == IW'(k)) begin
                win_frame_c = req_digits_i[32*k +: 32];
            end
        end
        win_onehot_c = N_REQ'(1) << win_idx_c;
    end

    // The ack cycle is the first GAP cycle; MIN_GAP further idle cycles follow it
    always_ff @(posedge clk_i) begin
        if (sync_reset_i) begin
            state         <= S_IDLE;
            last_grant    <= IW'(N_REQ - 1);
            cnt           <= '0;
            grant_o       <= '0;
            ack_o         <= '0;
            err_o         <= 1'b0;
            digits_o      <= '0;
            disp_strobe_o <= 1'b0;
        end else begin
            ack_o         <= '0;
            err_o         <= 1'b0;
            disp_strobe_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!busy_i && win_valid_c) begin
                        grant_o       <= win_onehot_c;
                        digits_o      <= win_frame_c;
                        last_grant    <= win_idx_c;
                        disp_strobe_o <= 1'b1;
                        state         <= S_STROBE;
                    end
                end
                S_STROBE: begin
                    cnt   <= '0;
                    state <= S_ACCEPT;
                end
                S_ACCEPT: begin
                    if (busy_i) begin
                        state <= S_RUN;
                    end else if (cnt == CW'(ACCEPT_TIMEOUT - 1)) begin
                        err_o   <= 1'b1;
                        ack_o   <= grant_o;
                        grant_o <= '0;
                        cnt     <= '0;
                        state   <= S_GAP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RUN: begin
                    if (!busy_i) begin
                        ack_o   <= grant_o;
                        grant_o <= '0;
                        cnt     <= '0;
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (cnt == CW'(MIN_GAP)) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_disp_arbiter.sv
// Self-checking bench for disp_arbiter: table-driven arbitration rows plus
// directed sequences for fairness, timeout, reset mid-run, request drop, MIN_GAP=0.
module tb_disp_arbiter;

    localparam logic [31:0] F0 = 32'h3F063F06;
    localparam logic [31:0] F1 = 32'h6D4F665B;
    localparam logic [31:0] F2 = 32'h5B3F5B6D;
    localparam logic [31:0] F3 = 32'h7F6F777C;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         rst;
    logic [3:0]   req;
    logic [127:0] digits;
    logic         busy;
    logic [3:0]   grant, ack;
    logic         err, strobe;
    logic [31:0]  dout;

    logic [1:0]   req2;
    logic [63:0]  digits2;
    logic         busy2;
    logic [1:0]   grant2, ack2;
    logic         err2, strobe2;
    logic [31:0]  dout2;

    disp_arbiter #(.N_REQ(4), .MIN_GAP(16), .ACCEPT_TIMEOUT(8)) u_dut (
        .clk_i(clk), .sync_reset_i(rst), .req_i(req), .req_digits_i(digits),
        .busy_i(busy), .grant_o(grant), .ack_o(ack), .err_o(err),
        .digits_o(dout), .disp_strobe_o(strobe)
    );

    disp_arbiter #(.N_REQ(2), .MIN_GAP(0), .ACCEPT_TIMEOUT(8)) u_dut2 (
        .clk_i(clk), .sync_reset_i(rst), .req_i(req2), .req_digits_i(digits2),
        .busy_i(busy2), .grant_o(grant2), .ack_o(ack2), .err_o(err2),
        .digits_o(dout2), .disp_strobe_o(strobe2)
    );

    int checks = 0;
    int errors = 0;
    int last_ack_cyc = 0;

    typedef struct {
        logic [3:0]  req;
        int          blen;
        logic [3:0]  exp_grant;
        logic [31:0] exp_digits;
    } row_t;

    row_t rows[7];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] actual=%h required=%h", nm, idx, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One full driver transaction on the 4-requester instance
    task automatic txn(input logic [3:0] rq, input int blen, input bit keep, input bit drop,
                       output logic [3:0] g, output logic [31:0] d_stb, output logic [31:0] d_ack,
                       output int nstb, output int nerr, output int alat,
                       output logic [3:0] av, output logic [3:0] av_next, output int gap);
        int n;
        n = 0; g = '0; d_stb = '0; d_ack = '0; nstb = 0; nerr = 0; alat = 0;
        av = '0; av_next = '0; gap = 0;
        req = rq;
        do begin @(negedge clk); n++; end while (!strobe && n < 200);
        chk("strobe_wait", 0, 32'(strobe), 32'd1);
        if (!strobe) return;
        g = grant; d_stb = dout; nstb = 1; gap = cyc - last_ack_cyc;
        if (drop) begin req = '0; digits = ~digits; end
        @(negedge clk);
        busy = 1'b1;
        nstb += int'(strobe); nerr += int'(err);
        repeat (blen) begin
            @(negedge clk);
            nstb += int'(strobe); nerr += int'(err);
        end
        busy = 1'b0;
        do begin
            @(negedge clk);
            alat++;
            nstb += int'(strobe); nerr += int'(err);
        end while (ack == '0 && alat < 100);
        av = ack; d_ack = dout; last_ack_cyc = cyc;
        if (!keep) req = '0;
        if (drop) digits = ~digits;
        @(negedge clk);
        av_next = ack; nstb += int'(strobe); nerr += int'(err);
    endtask

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  g, av, avn;
        logic [31:0] ds, da;
        int ns, ne, al, gp, n, sc, ec, lack;
        logic [1:0]  g2;
        logic [3:0]  fair_exp [5];
        logic [1:0]  g2_exp [4];

        rows[0] = '{4'b0100, 50, 4'b0100, F2};
        rows[1] = '{4'b1001,  5, 4'b1000, F3};
        rows[2] = '{4'b1001,  5, 4'b0001, F0};
        rows[3] = '{4'b0110,  5, 4'b0010, F1};
        rows[4] = '{4'b0110,  5, 4'b0100, F2};
        rows[5] = '{4'b1011,  5, 4'b1000, F3};
        rows[6] = '{4'b0111,  5, 4'b0001, F0};
        fair_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        g2_exp   = '{2'b01, 2'b10, 2'b01, 2'b10};

        rst = 1'b1; req = '0; busy = 1'b0; digits = {F3, F2, F1, F0};
        req2 = '0; busy2 = 1'b0; digits2 = {F1, F0};
        repeat (3) @(negedge clk);
        chk("rst_grant", 0, 32'(grant), 32'd0);
        chk("rst_ack", 0, 32'(ack), 32'd0);
        chk("rst_err", 0, 32'(err), 32'd0);
        chk("rst_digits", 0, dout, 32'd0);
        chk("rst_strobe", 0, 32'(strobe), 32'd0);
        chk("rst_grant2", 0, 32'(grant2), 32'd0);
        rst = 1'b0;

        // Arbitration table
        for (int r = 0; r < 7; r++) begin
            txn(rows[r].req, rows[r].blen, 1'b0, 1'b0, g, ds, da, ns, ne, al, av, avn, gp);
            chk("row_grant", r, 32'(g), 32'(rows[r].exp_grant));
            chk("row_digits", r, ds, rows[r].exp_digits);
            chk("row_strobes", r, 32'(ns), 32'd1);
            chk("row_err", r, 32'(ne), 32'd0);
            chk("row_ack", r, 32'(av), 32'(rows[r].exp_grant));
            chk("row_ack_lat", r, 32'(al), 32'd1);
            chk("row_ack_pulse", r, 32'(avn), 32'd0);
            chk("row_digits_hold", r, da, rows[r].exp_digits);
        end

        // Fairness with all requests held
        do_reset();
        for (int t = 0; t < 5; t++) begin
            txn(4'b1111, 3, 1'b1, 1'b0, g, ds, da, ns, ne, al, av, avn, gp);
            chk("fair_grant", t, 32'(g), 32'(fair_exp[t]));
            if (t > 0) chk("fair_gap", t, 32'(gp), 32'd18);
        end
        req = '0;

        // Request drop and frame change during service
        do_reset();
        txn(4'b1000, 8, 1'b0, 1'b1, g, ds, da, ns, ne, al, av, avn, gp);
        chk("drop_grant", 0, 32'(g), 32'b1000);
        chk("drop_digits", 0, da, F3);
        chk("drop_ack", 0, 32'(av), 32'b1000);
        ns = 0;
        repeat (40) begin @(negedge clk); ns += int'(strobe); end
        chk("drop_no_regrant", 0, 32'(ns), 32'd0);
        txn(4'b0001, 3, 1'b0, 1'b0, g, ds, da, ns, ne, al, av, avn, gp);
        chk("drop_next_grant", 0, 32'(g), 32'b0001);
        chk("drop_next_digits", 0, ds, F0);

        // Accept timeout with busy never rising
        do_reset();
        req = 4'b0010; n = 0;
        do begin @(negedge clk); n++; end while (!strobe && n < 200);
        chk("to_strobe", 0, 32'(strobe), 32'd1);
        chk("to_grant", 0, 32'(grant), 32'b0010);
        sc = cyc; n = 0;
        do begin @(negedge clk); n++; end while (!err && n < 50);
        ec = cyc;
        chk("to_err_lat", 0, 32'(ec - sc), 32'd9);
        chk("to_ack", 0, 32'(ack), 32'b0010);
        @(negedge clk);
        chk("to_err_pulse", 0, 32'(err), 32'd0);
        n = 0;
        do begin @(negedge clk); n++; end while (!strobe && n < 200);
        chk("to_next_gap", 0, 32'(cyc - ec), 32'd18);
        chk("to_next_grant", 0, 32'(grant), 32'b0010);
        req = '0;

        // Reset while the driver is busy
        do_reset();
        req = 4'b0100; n = 0;
        do begin @(negedge clk); n++; end while (!strobe && n < 200);
        @(negedge clk);
        busy = 1'b1;
        repeat (5) @(negedge clk);
        chk("rr_run_grant", 0, 32'(grant), 32'b0100);
        req = 4'b1111; rst = 1'b1;
        @(negedge clk);
        chk("rr_grant", 0, 32'(grant), 32'd0);
        chk("rr_ack", 0, 32'(ack), 32'd0);
        chk("rr_err", 0, 32'(err), 32'd0);
        chk("rr_digits", 0, dout, 32'd0);
        chk("rr_strobe", 0, 32'(strobe), 32'd0);
        rst = 1'b0; ns = 0;
        repeat (10) begin @(negedge clk); ns += int'(strobe); end
        chk("rr_no_strobe", 0, 32'(ns), 32'd0);
        busy = 1'b0; n = 0;
        do begin @(negedge clk); n++; end while (!strobe && n < 200);
        chk("rr_lat", 0, 32'(n), 32'd1);
        chk("rr_first_grant", 0, 32'(grant), 32'b0001);
        req = '0;
        do_reset();

        // MIN_GAP = 0, two requesters alternating
        req2 = 2'b11; lack = 0;
        for (int t = 0; t < 4; t++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!strobe2 && n < 200);
            g2 = grant2;
            chk("g0_grant", t, 32'(g2), 32'(g2_exp[t]));
            chk("g0_digits", t, dout2, (g2 == 2'b01) ? F0 : F1);
            if (t > 0) chk("g0_gap", t, 32'(cyc - lack), 32'd2);
            @(negedge clk);
            busy2 = 1'b1;
            repeat (2) @(negedge clk);
            busy2 = 1'b0; n = 0;
            do begin @(negedge clk); n++; end while (ack2 == '0 && n < 100);
            chk("g0_ack", t, 32'(ack2), 32'(g2));
            lack = cyc;
        end
        req2 = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
